mc_ctrl: RTL and testbench

Multi-cycle main control FSM for the MIPS-subset datapath. Decodes the 6-bit opcode from the instruction register and sequences fetch, decode, execute, memory and write-back over several clocks. Drives every datapath enable and mux select, plus the 2-bit `alu_op` consumed by the ALU control decoder. Stalls on a memory-ready handshake.

---
 rtl/mc_pkg.sv | 41 ++++
 rtl/mc_ctrl.sv | 132 +++++++++++++
 tb/tb_mc_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// opcodes, FSM state codes and datapath select values.
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PCS_ALU   = 2'b00;
    localparam logic [1:0] PCS_OUT   = 2'b01;
    localparam logic [1:0] PCS_JMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/mem/wb
// and drives every datapath enable and mux select.
import mc_pkg::*;

module mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_rdy,
    output logic       pc_wr,
    output logic       pc_wr_cond,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_wr,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_RST;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_RST;
        endcase
    end

    // Moore decode, except the FETCH writes which wait on mem_rdy
    always_comb begin
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        pc_src     = PCS_ALU;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_wr     = mem_rdy;
                pc_wr     = mem_rdy;
            end
            S_DECODE: begin
                alu_src_b = SRCB_BR;
                illegal   = !(op inside {OP_R, OP_LW, OP_SW,
                                         OP_BEQ, OP_J, OP_ADDI});
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_wr_cond = 1'b1;
                pc_src     = PCS_OUT;
            end
            S_JUMP: begin
                pc_wr  = 1'b1;
                pc_src = PCS_JMP;
            end
            S_ADDIWB: reg_wr = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: instruction-level model builds the
// expected per-cycle outputs, one process compares every cycle.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
        logic [3:0] state;
    } out_t;

    localparam logic [5:0] R_OP = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J_OP = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       mem_rdy = 1'b0;
    logic       pc_wr, pc_wr_cond, iord, mem_rd, mem_wr, ir_wr;
    logic       reg_dst, mem_to_reg, reg_wr, alu_src_a, illegal;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state;

    out_t got, exp_o;
    bit   chk_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_rdy(mem_rdy),
        .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond), .pc_src(pc_src),
        .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_wr(ir_wr),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_wr(reg_wr),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    assign got = '{pc_wr, pc_wr_cond, pc_src, iord, mem_rd, mem_wr,
                   ir_wr, reg_dst, mem_to_reg, reg_wr, alu_src_a,
                   alu_src_b, alu_op, illegal, state};

    function automatic bit known(logic [5:0] o);
        return o == R_OP || o == LW || o == SW ||
               o == BEQ || o == J_OP || o == ADDI;
    endfunction

    // Output table of the controller, one row per named step
    function automatic out_t model(int st, bit rdy, logic [5:0] o);
        out_t m = '0;
        m.state = 4'(st);
        case (st)
            1:  begin m.mem_rd = 1; m.alu_src_b = 2'b01;
                      m.ir_wr = rdy; m.pc_wr = rdy; end
            2:  begin m.alu_src_b = 2'b11; m.illegal = !known(o); end
            3:  begin m.alu_src_a = 1; m.alu_src_b = 2'b10; end
            4:  begin m.mem_rd = 1; m.iord = 1; end
            5:  begin m.reg_wr = 1; m.mem_to_reg = 1; end
            6:  begin m.mem_wr = 1; m.iord = 1; end
            7:  begin m.alu_src_a = 1; m.alu_op = 2'b10; end
            8:  begin m.reg_wr = 1; m.reg_dst = 1; end
            9:  begin m.alu_src_a = 1; m.alu_op = 2'b01;
                      m.pc_wr_cond = 1; m.pc_src = 2'b01; end
            10: begin m.pc_wr = 1; m.pc_src = 2'b10; end
            11: begin m.alu_src_a = 1; m.alu_src_b = 2'b10; end
            12: m.reg_wr = 1;
            default: ;
        endcase
        return m;
    endfunction

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            vectors++;
            if (got !== exp_o) begin
                miscompares++;
                $display("FAIL cycle t=%0t got %h (state %0d) want %h (state %0d)",
                         $time, got, got.state, exp_o, exp_o.state);
            end
        end
    end

    task automatic cyc(int st, bit rdy, logic [5:0] o, bit rn = 1'b1);
        @(negedge clk);
        #1;
        rst_n   = rn;
        mem_rdy = rdy;
        op      = o;
        exp_o   = model(st, rdy, o);
        chk_en  = 1'b1;
    endtask

    task automatic lit(string name, logic [7:0] g, logic [7:0] w);
        vectors++;
        if (g !== w) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, g, w);
        end
    endtask

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction: fetch stalls fs, memory-phase stalls ms
    task automatic instr(logic [5:0] o, int fs, int ms);
        for (int i = 0; i < fs; i++) cyc(1, 1'b0, 6'($urandom));
        cyc(1, 1'b1, 6'($urandom));
        cyc(2, rnd(), o);
        if (o == LW || o == SW) begin
            cyc(3, rnd(), o);
            for (int i = 0; i < ms; i++) cyc(o == LW ? 4 : 6, 1'b0, o);
            cyc(o == LW ? 4 : 6, 1'b1, o);
            if (o == LW) cyc(5, rnd(), o);
        end else if (o == R_OP) begin
            cyc(7, rnd(), o); cyc(8, rnd(), o);
        end else if (o == BEQ) begin
            cyc(9, rnd(), o);
        end else if (o == J_OP) begin
            cyc(10, rnd(), o);
        end else if (o == ADDI) begin
            cyc(11, rnd(), o); cyc(12, rnd(), o);
        end
    endtask

    initial begin
        cyc(0, 1'b1, 6'd0, 1'b0);
        cyc(0, 1'b0, 6'd0, 1'b0);
        cyc(0, 1'b1, 6'd0, 1'b1);

        instr(R_OP, 0, 0);
        instr(LW, 0, 2);
        instr(J_OP, 0, 0);
        instr(ADDI, 0, 0);
        instr(SW, 0, 0);
        instr(SW, 0, 3);
        instr(LW, 1, 0);
        instr(R_OP, 3, 0);
        instr(6'b111111, 0, 0);
        instr(6'b000001, 0, 0);
        instr(BEQ, 0, 0);

        // Literal pins of the model on key cycles
        cyc(1, 1'b0, 6'd0);
        #1 lit("fetch_stall", {2'b0, ir_wr, pc_wr, state}, 8'h01);
        cyc(1, 1'b1, 6'd0);
        #1 lit("fetch_go", {2'b0, ir_wr, pc_wr, state}, 8'h31);
        cyc(2, 1'b1, BEQ);
        cyc(9, 1'b1, BEQ);
        #1 lit("beq_ctl", {3'b0, pc_wr_cond, alu_op, pc_src}, 8'h15);
        cyc(1, 1'b1, 6'd0);
        cyc(2, 1'b1, J_OP);
        cyc(10, 1'b0, J_OP);
        #1 lit("j_ctl", {5'b0, pc_wr, pc_src}, 8'h06);
        cyc(1, 1'b1, 6'd0);
        cyc(2, 1'b1, 6'b111111);
        #1 lit("illegal", {illegal, 3'b0, state}, 8'h82);
        cyc(1, 1'b1, 6'd0);
        #1 lit("illegal_clr", {illegal, 3'b0, state}, 8'h01);
        cyc(2, 1'b1, R_OP);
        cyc(7, 1'b1, R_OP);
        #1 lit("r_exec", {6'b0, alu_op}, 8'h02);
        cyc(8, 1'b1, R_OP);
        #1 lit("r_wb", {6'b0, reg_wr, reg_dst}, 8'h03);

        // Reset asserted in the middle of a MEMRD stall
        cyc(1, 1'b1, 6'd0);
        cyc(2, 1'b1, LW);
        cyc(3, 1'b1, LW);
        cyc(4, 1'b0, LW);
        cyc(4, 1'b0, LW);
        cyc(0, 1'b0, LW, 1'b0);
        #1 lit("rst_mid", {mem_rd, iord, 2'b0, state}, 8'h00);
        cyc(0, 1'b1, LW, 1'b0);
        cyc(0, 1'b1, LW, 1'b1);
        cyc(1, 1'b1, 6'd0);
        #1 lit("rst_fetch", {mem_rd, 3'b0, state}, 8'h81);
        cyc(2, 1'b1, ADDI);
        cyc(11, 1'b0, ADDI);
        cyc(12, 1'b1, ADDI);
        cyc(1, 1'b1, 6'd0);

        @(negedge clk);
        chk_en = 1'b0;
        #5;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
